mul_share_ctrl: RTL

Round-robin scheduler that shares one registered DATA_WIDTH×DATA_WIDTH multiplier among NUM_REQ requesters.

- Accepts one operand pair per transaction over a valid/ready handshake.
- Drives the multiplier's enable and operands, then returns the product tagged with the requester index over a valid/ready response channel.
- Sits between the attention-datapath requesters and the shared multiplier unit.

---
 rtl/mul_share_ctrl_if.sv | 27 ++
 rtl/mul_share_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl_if.sv
// Request and response channels between the attention-datapath requesters
// and the shared-multiplier scheduler.
interface mul_share_ctrl_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PROD_WIDTH = 2 * DATA_WIDTH,
    parameter int ID_WIDTH   = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [PROD_WIDTH-1:0]         rsp_data;
    logic [ID_WIDTH-1:0]           rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin scheduler sharing one registered multiplier among NUM_REQ
// requesters: grant (IDLE) -> enable multiplier (MUL) -> return product (RESP).
module mul_share_ctrl #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PROD_WIDTH = 2 * DATA_WIDTH,
    parameter int ID_WIDTH   = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mul_share_ctrl_if.slave       bus,
    output logic                  mul_ebl,
    output logic [DATA_WIDTH-1:0] mul_a,
    output logic [DATA_WIDTH-1:0] mul_b,
    input  logic [PROD_WIDTH-1:0] mul_out,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  op_count
);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, RESP = 2'd2} state_t;

    localparam logic [ID_WIDTH:0]   NUM_REQ_W = (ID_WIDTH + 1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

    state_t                state_reg, state_next;
    logic [ID_WIDTH-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [ID_WIDTH-1:0]   id_reg, id_next;
    logic [DATA_WIDTH-1:0] op_a_reg, op_a_next;
    logic [DATA_WIDTH-1:0] op_b_reg, op_b_next;
    logic [CNT_WIDTH-1:0]  op_count_reg, op_count_next;

    logic [DATA_WIDTH-1:0] slice_a [NUM_REQ];
    logic [DATA_WIDTH-1:0] slice_b [NUM_REQ];
    logic [ID_WIDTH-1:0]   cand_idx [NUM_REQ];
    logic                  cand_valid [NUM_REQ];
    logic [NUM_REQ-1:0]    grant_onehot;
    logic                  grant_found;
    logic [ID_WIDTH-1:0]   grant_idx;

    // Candidate gi is requester (rr_ptr + 1 + gi) mod NUM_REQ, so candidate 0
    // is the one with highest priority this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [ID_WIDTH:0] sum;
            assign slice_a[gi]      = bus.req_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign slice_b[gi]      = bus.req_b[gi*DATA_WIDTH +: DATA_WIDTH];
            assign sum              = {1'b0, rr_ptr_reg} + (ID_WIDTH + 1)'(gi + 1);
            assign cand_idx[gi]     = (sum >= NUM_REQ_W) ? ID_WIDTH'(sum - NUM_REQ_W)
                                                         : sum[ID_WIDTH-1:0];
            assign cand_valid[gi]   = bus.req_valid[cand_idx[gi]];
            assign grant_onehot[gi] = (grant_idx == ID_WIDTH'(gi));
        end
    endgenerate

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && cand_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= LAST_ID;
            id_reg       <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            id_reg       <= id_next;
            op_a_reg     <= op_a_next;
            op_b_reg     <= op_b_next;
            op_count_reg <= op_count_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        id_next       = id_reg;
        op_a_next     = op_a_reg;
        op_b_next     = op_b_reg;
        op_count_next = op_count_reg;
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        bus.rsp_id    = '0;
        mul_ebl       = 1'b0;
        mul_a         = '0;
        mul_b         = '0;
        case (state_reg)
            IDLE: begin
                // No grant while reset is held, so every output reads 0 in reset.
                if (grant_found && rst) begin
                    bus.req_ready = grant_onehot;
                    op_a_next     = slice_a[grant_idx];
                    op_b_next     = slice_b[grant_idx];
                    id_next       = grant_idx;
                    rr_ptr_next   = grant_idx;
                    state_next    = MUL;
                end
            end
            MUL: begin
                mul_ebl    = 1'b1;
                mul_a      = op_a_reg;
                mul_b      = op_b_reg;
                state_next = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = mul_out;
                bus.rsp_id    = id_reg;
                if (bus.rsp_ready) begin
                    op_count_next = op_count_reg + CNT_WIDTH'(1);
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state_reg != IDLE);
    assign op_count = op_count_reg;

endmodule
